// File: rtl/alu_op_sequencer.sv
// Byte-serial command sequencer feeding a combinational ALU: command, A, B bytes in,
// result/zero captured and held until accepted; keeps an accumulator for chained ops.
module alu_op_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [DATA_W-1:0] acc_out
);

    localparam int unsigned ACC_BIT = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] acc, acc_d;
    logic [DATA_W-1:0] a_d, b_d, rd_d;
    logic [SEL_W-1:0]  sel_d;
    logic              rz_d, rv_d, err_d;
    logic              accept;

    assign in_ready = ena & ((state == IDLE) || (state == LOAD_A) || (state == LOAD_B));
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);
    assign acc_out  = acc;

    // Next-state and next-register values; ena gating lives in the register process.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        acc_d   = acc;
        a_d     = alu_a;
        b_d     = alu_b;
        sel_d   = alu_sel;
        rd_d    = res_data;
        rz_d    = res_zero;
        rv_d    = res_valid;
        err_d   = timeout_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    sel_d = in_data[SEL_W-1:0];
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (in_data[ACC_BIT]) begin
                        a_d     = acc;
                        state_d = LOAD_B;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    cnt_d = '0;
                    if (state == LOAD_A) begin
                        a_d     = in_data;
                        state_d = LOAD_B;
                    end else begin
                        b_d     = in_data;
                        state_d = EXEC;
                    end
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT))) begin
                    // Abort leaves accumulator and result registers untouched.
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                rd_d    = alu_result;
                rz_d    = alu_zero;
                acc_d   = alu_result;
                rv_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything freezes while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            res_data    <= '0;
            res_zero    <= 1'b0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (ena) begin
            state       <= state_d;
            cnt         <= cnt_d;
            acc         <= acc_d;
            alu_a       <= a_d;
            alu_b       <= b_d;
            alu_sel     <= sel_d;
            res_data    <= rd_d;
            res_zero    <= rz_d;
            res_valid   <= rv_d;
            timeout_err <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized transaction-level bench for alu_op_sequencer with a behavioural ALU stand-in
// and a transaction model (accumulator, sticky error, idle-gap timeout rule).
module tb_alu_op_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          in_ready, res_zero, res_valid, busy, timeout_err, alu_zero;
    logic [DW-1:0] alu_a, alu_b, alu_result, res_data, acc_out;
    logic [SW-1:0] alu_sel;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  rnd_stall = 1'b0;
    logic [DW-1:0] acc_m = '0;
    logic          err_m = 1'b0;

    alu_op_sequencer #(.DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .res_data(res_data),
        .res_zero(res_zero), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .timeout_err(timeout_err), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[6:0], 1'b0};
            3'd6:    return {1'b0, a[7:1]};
            default: return b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_sel, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rk();
        if (rnd_stall && ($urandom_range(0, 3) == 0)) return int'($urandom_range(1, 4));
        return 0;
    endfunction

    // ena held low for k cycles with a live-looking handshake; nothing may be accepted.
    task automatic stall(input int k);
        for (int i = 0; i < k; i++) begin
            ena       = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            res_ready = 1'($urandom);
            tick();
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        end
        ena       = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int k);
        stall(k);
        ena      = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check_eq("send_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // g idle ena-high cycles, optionally interleaved with frozen (ena low) cycles.
    task automatic idle_gap(input int g);
        for (int i = 0; i < g; i++) begin
            stall(rk());
            ena      = 1'b1;
            in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic expect_abort();
        idle_gap(int'(TO));
        check_eq("pre_abort_busy", 32'(busy), 32'd1);
        idle_gap(1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_err", 32'(timeout_err), 32'd1);
        check_eq("abort_res_valid", 32'(res_valid), 32'd0);
        check_eq("abort_acc", 32'(acc_out), 32'(acc_m));
        err_m = 1'b1;
    endtask

    // One command; a gap above TO idle cycles aborts the transaction.
    task automatic do_txn(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input int ga, input int gb, input int sb, input int hold);
        logic [7:0] a_use;
        logic [7:0] exp;
        check_eq("pre_err", 32'(timeout_err), 32'(err_m));
        check_eq("pre_busy", 32'(busy), 32'd0);
        send_byte(cmd, rk());
        err_m = 1'b0;
        check_eq("cmd_err_clr", 32'(timeout_err), 32'd0);
        check_eq("cmd_sel", 32'(alu_sel), 32'(cmd[2:0]));
        check_eq("cmd_busy", 32'(busy), 32'd1);
        if (cmd[3]) begin
            a_use = acc_m;
            check_eq("acc_to_a", 32'(alu_a), 32'(acc_m));
        end else begin
            if (ga > int'(TO)) begin
                expect_abort();
                return;
            end
            idle_gap(ga);
            send_byte(a, rk());
            a_use = a;
            check_eq("load_a", 32'(alu_a), 32'(a));
        end
        if (gb > int'(TO)) begin
            expect_abort();
            return;
        end
        idle_gap(gb);
        send_byte(b, (sb > 0) ? sb : rk());
        check_eq("load_b", 32'(alu_b), 32'(b));
        check_eq("exec_res_valid", 32'(res_valid), 32'd0);
        exp = alu_f(cmd[2:0], a_use, b);
        tick();
        check_eq("res_valid", 32'(res_valid), 32'd1);
        check_eq("res_data", 32'(res_data), 32'(exp));
        check_eq("res_zero", 32'(res_zero), 32'(exp == 8'd0));
        check_eq("acc_out", 32'(acc_out), 32'(exp));
        acc_m = exp;
        for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                stall(1);
            end else begin
                ena       = 1'b1;
                res_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 8'($urandom);
                #1;
                check_eq("done_in_ready", 32'(in_ready), 32'd0);
                tick();
            end
            check_eq("hold_valid", 32'(res_valid), 32'd1);
            check_eq("hold_data", 32'(res_data), 32'(exp));
        end
        ena       = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("hs_res_valid", 32'(res_valid), 32'd0);
        check_eq("hs_busy", 32'(busy), 32'd0);
        check_eq("hs_data_held", 32'(res_data), 32'(exp));
        check_eq("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Async reset while the result is being produced (extra=0) or held (extra=1).
    task automatic reset_mid(input int extra);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        for (int i = 0; i < extra; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", 32'(res_data), 32'd0);
        check_eq("rst_acc", 32'(acc_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_sel", 32'(alu_sel), 32'd0);
        check_eq("rst_err", 32'(timeout_err), 32'd0);
        #2;
        rst_n = 1'b1;
        acc_m = '0;
        err_m = 1'b0;
        tick();
    endtask

    initial begin
        #3;
        check_eq("init_res_valid", 32'(res_valid), 32'd0);
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_acc", 32'(acc_out), 32'd0);
        check_eq("init_in_ready", 32'(in_ready), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        ena = 1'b1;

        do_txn(8'h00, 8'h12, 8'h34, 0, 0, 0, 0);
        do_txn(8'h09, 8'h00, 8'h05, 0, 0, 0, 0);
        do_txn(8'h04, 8'h5a, 8'ha5, 1, 2, 0, 10);
        do_txn(8'h02, 8'h0f, 8'hf0, 5, 0, 0, 0);
        do_txn(8'h03, 8'h01, 8'h80, 4, 4, 0, 0);
        do_txn(8'h01, 8'h33, 8'h33, 0, 5, 0, 0);
        do_txn(8'h05, 8'h81, 8'h10, 0, 4, 5, 2);
        do_txn(8'hf8, 8'h00, 8'h00, 0, 0, 0, 0);

        rnd_stall = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int ga, gb;
            ga = ($urandom_range(0, 7) == 0) ? int'(TO) + 1 : int'($urandom_range(0, TO));
            gb = ($urandom_range(0, 7) == 0) ? int'(TO) + 1 : int'($urandom_range(0, TO));
            do_txn(8'($urandom), 8'($urandom), 8'($urandom), ga, gb, 0, int'($urandom_range(0, 12)));
        end
        rnd_stall = 1'b0;

        reset_mid(0);
        do_txn(8'h08, 8'h00, 8'h5a, 0, 0, 0, 0);
        reset_mid(1);
        do_txn(8'h0f, 8'h00, 8'h3c, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
